// File: rtl/fifo_drain.sv
// Drains an upstream FIFO with 1-cycle read latency into a valid/ready stream,
// through a 3-entry skid buffer, and marks PKT_LEN-beat packets with m_last.
module fifo_drain #(
    parameter int FIFO_WIDTH = 16,
    parameter int PKT_LEN    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [15:0]           pkt_count,
    output logic                  err_underflow
);

    localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

    typedef logic [1:0] ptr_t;

    logic [FIFO_WIDTH-1:0] buf_mem [0:2];
    ptr_t                  head;
    ptr_t                  tail;
    logic [1:0]            occ;
    logic                  inflight;
    logic [BEAT_W-1:0]     beat;
    logic [2:0]            fill;
    logic                  push;
    logic                  pop;

    function automatic ptr_t ptr_next(input ptr_t p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        fill       = {1'b0, occ} + {2'b00, inflight};
        // Reads are budgeted against words already buffered or still in flight,
        // so a word returned by the FIFO always has a free slot waiting for it.
        fifo_rd_en = !rst && enable && !fifo_empty && (fill <= 3'd2);
        push       = inflight;
        m_valid    = (occ != 2'd0);
        pop        = m_valid && m_ready;
        m_data     = m_valid ? buf_mem[head] : '0;
        m_last     = m_valid && (beat == LAST_BEAT);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            head          <= '0;
            tail          <= '0;
            occ           <= '0;
            inflight      <= 1'b0;
            beat          <= '0;
            pkt_count     <= '0;
            err_underflow <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            if (push) tail <= ptr_next(tail);
            if (pop)  head <= ptr_next(head);

            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase

            if (pop) begin
                beat <= (beat == LAST_BEAT) ? '0 : beat + BEAT_W'(1);
                if (m_last) pkt_count <= pkt_count + 16'd1;
            end

            if (fifo_rd_en && fifo_empty) err_underflow <= 1'b1;
        end
    end

    // NOTE: buffer storage is deliberately not reset; clearing occ makes stale
    // entries unreachable, and m_data is forced to zero while nothing is valid.
    always_ff @(posedge clk) begin
        if (push) buf_mem[tail] <= fifo_data_out;
    end

endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: behavioural upstream FIFO, scoreboard of words read
// with their earliest-visible cycle, and directed scenarios with literal checks.
module tb_fifo_drain;

    localparam int W  = 16;
    localparam int PL = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         fifo_empty;
    logic [W-1:0] fifo_data_out;
    logic         fifo_rd_en;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic         m_last;
    logic [15:0]  pkt_count;
    logic         err_underflow;

    always #5 clk = ~clk;

    fifo_drain #(.FIFO_WIDTH(W), .PKT_LEN(PL)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data_out(fifo_data_out), .fifo_rd_en(fifo_rd_en),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .pkt_count(pkt_count), .err_underflow(err_underflow)
    );

    typedef struct {
        logic [W-1:0] data;
        int           avail;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] fifo_q[$];
    logic [W-1:0] xfer_data[$];
    bit           xfer_last[$];
    int           xfer_cyc[$];
    int           rd_cyc[$];

    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    int           beat_m   = 0;
    int           pkt_m    = 0;
    logic         rd_seen  = 1'b0;
    logic         exp_valid;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data;
    logic         prev_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Upstream FIFO: a read strobed in one cycle presents its word the next cycle.
    initial begin
        fifo_empty    = 1'b1;
        fifo_data_out = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rd_seen) fifo_data_out = (fifo_q.size() > 0) ? fifo_q.pop_front() : 16'hDEAD;
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Model: each word read becomes visible two cycles after its read and leaves
    // in read order on a handshake; packets are every PL transfers since reset.
    always @(negedge clk) begin
        if (rst) begin
            check("rd_en_in_reset", 32'(fifo_rd_en), 32'd0);
            exp_q.delete();
            beat_m     = 0;
            pkt_m      = 0;
            prev_stall = 1'b0;
        end else begin
            exp_valid = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
            check("m_valid", 32'(m_valid), 32'(exp_valid));
            check("rd_en", 32'(fifo_rd_en),
                  32'(enable && !fifo_empty && (exp_q.size() <= 2)));
            check("m_last", 32'(m_last), 32'(exp_valid && (beat_m == PL - 1)));
            if (exp_valid) check("m_data", 32'(m_data), 32'(exp_q[0].data));
            check("pkt_count", 32'(pkt_count), 32'(pkt_m[15:0]));
            check("err_underflow", 32'(err_underflow), 32'd0);
            check("occupancy", 32'(exp_q.size() + int'(fifo_rd_en) <= 3), 32'd1);
            if (prev_stall) begin
                check("hold_data", 32'(m_data), 32'(prev_data));
                check("hold_last", 32'(m_last), 32'(prev_last));
            end
            if (exp_valid && m_ready) begin
                xfer_data.push_back(m_data);
                xfer_last.push_back(m_last);
                xfer_cyc.push_back(cyc);
                void'(exp_q.pop_front());
                if (beat_m == PL - 1) begin
                    beat_m = 0;
                    pkt_m  = pkt_m + 1;
                end else begin
                    beat_m = beat_m + 1;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (fifo_rd_en) begin
                rd_cyc.push_back(cyc);
                exp_q.push_back('{data: (fifo_q.size() > 0) ? fifo_q[0] : 16'hDEAD,
                                  avail: cyc + 2});
            end
        end
        rd_seen = fifo_rd_en;
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic push_words(input logic [W-1:0] base, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(base + W'(i));
    endtask

    task automatic wait_drained(input string name, input int budget, input bit rand_ready);
        int n = 0;
        while ((exp_q.size() > 0 || fifo_q.size() > 0) && n < budget) begin
            if (rand_ready) m_ready = 1'($urandom_range(0, 1));
            tick(1);
            n++;
        end
        m_ready = 1'b1;
        check(name, 32'(exp_q.size() + fifo_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mx, mr;
        rst     = 1'b1;
        enable  = 1'b0;
        m_ready = 1'b0;
        tick(3);
        rst = 1'b0;

        // Reset state.
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_pkt_count", 32'(pkt_count), 32'd0);
        check("rst_err", 32'(err_underflow), 32'd0);

        // 16 preloaded words stream out back to back as two packets.
        enable  = 1'b1;
        m_ready = 1'b1;
        mx = xfer_data.size();
        push_words(16'h0001, 16);
        wait_drained("stream_timeout", 100, 1'b0);
        check("stream_count", 32'(xfer_data.size() - mx), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check("stream_data", 32'(xfer_data[mx + i]), 32'(i + 1));
            check("stream_last", 32'(xfer_last[mx + i]), 32'(i == 7 || i == 15));
        end
        check("stream_back_to_back", 32'(xfer_cyc[mx + 15] - xfer_cyc[mx]), 32'd15);
        check("stream_pkt_count", 32'(pkt_count), 32'd2);

        // Backpressure: reads stop at three, head word held, then full drain.
        do_reset();
        m_ready = 1'b0;
        mx = xfer_data.size();
        mr = rd_cyc.size();
        push_words(16'h0011, 20);
        tick(10);
        check("stall_reads", 32'(rd_cyc.size() - mr), 32'd3);
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_head", 32'(m_data), 32'h0011);
        m_ready = 1'b1;
        wait_drained("stall_timeout", 100, 1'b0);
        check("stall_count", 32'(xfer_data.size() - mx), 32'd20);
        check("stall_first", 32'(xfer_data[mx]), 32'h0011);
        check("stall_final", 32'(xfer_data[xfer_data.size() - 1]), 32'h0024);

        // Single word: one read, valid two cycles later.
        do_reset();
        mx = xfer_data.size();
        mr = rd_cyc.size();
        push_words(16'hABCD, 1);
        wait_drained("single_timeout", 50, 1'b0);
        tick(2);
        check("single_reads", 32'(rd_cyc.size() - mr), 32'd1);
        check("single_count", 32'(xfer_data.size() - mx), 32'd1);
        check("single_data", 32'(xfer_data[mx]), 32'hABCD);
        check("single_latency", 32'(xfer_cyc[mx] - rd_cyc[mr]), 32'd2);
        check("single_err", 32'(err_underflow), 32'd0);

        // Enable dropped mid-stream: no new reads, buffer drains, then resume.
        do_reset();
        mx = xfer_data.size();
        push_words(16'h0100, 30);
        tick(6);
        enable = 1'b0;
        mr = rd_cyc.size();
        tick(10);
        check("pause_reads", 32'(rd_cyc.size() - mr), 32'd0);
        check("pause_drained", 32'(exp_q.size()), 32'd0);
        check("pause_valid", 32'(m_valid), 32'd0);
        enable = 1'b1;
        wait_drained("pause_timeout", 100, 1'b0);
        check("pause_count", 32'(xfer_data.size() - mx), 32'd30);
        check("pause_final", 32'(xfer_data[xfer_data.size() - 1]), 32'h011D);

        // Reset with two buffered words and one in flight discards all three.
        do_reset();
        m_ready = 1'b0;
        push_words(16'h0A01, 3);
        tick(3);
        check("pre_rst_outstanding", 32'(exp_q.size()), 32'd3);
        check("pre_rst_valid", 32'(m_valid), 32'd1);
        do_reset();
        check("post_rst_valid", 32'(m_valid), 32'd0);
        check("post_rst_data", 32'(m_data), 32'd0);
        check("post_rst_last", 32'(m_last), 32'd0);
        check("post_rst_pkt", 32'(pkt_count), 32'd0);
        m_ready = 1'b1;
        mx = xfer_data.size();
        push_words(16'h0B01, 4);
        wait_drained("post_rst_timeout", 50, 1'b0);
        check("post_rst_count", 32'(xfer_data.size() - mx), 32'd4);
        check("post_rst_first", 32'(xfer_data[mx]), 32'h0B01);

        // 1000 words under random backpressure.
        do_reset();
        mx = xfer_data.size();
        push_words(16'h2000, 1000);
        wait_drained("random_timeout", 8000, 1'b1);
        tick(2);
        check("random_count", 32'(xfer_data.size() - mx), 32'd1000);
        for (int i = 0; i < 1000; i++) begin
            check("random_data", 32'(xfer_data[mx + i]), 32'(16'h2000 + 16'(i)));
            check("random_last", 32'(xfer_last[mx + i]), 32'(i % 8 == 7));
        end
        check("random_pkt_count", 32'(pkt_count), 32'd125);
        check("random_err", 32'(err_underflow), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
